// File: rtl/rom_page_loader.sv
// ROM download to SDRAM page loader: maps file bytes onto {area, page, offset} and queues them in a 2-deep write FIFO.
// Optional ROM_PAGE_LOADER_MAP_EN adds a per-page "loaded" map queried through map_page/map_valid.
module rom_page_loader #(
    parameter int PAGE_BITS      = 8,
    parameter int PAGE_SIZE_BITS = 14,
    parameter int NUM_BANKS      = 2,
    parameter int COMBO_PAGE     = (1 << PAGE_BITS) - 1,
    localparam int BANK_W        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int ADDR_W        = 1 + PAGE_BITS + PAGE_SIZE_BITS
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 dl_active,
    input  logic                 dl_wr,
    input  logic [24:0]          dl_addr,
    input  logic [7:0]           dl_data,
    input  logic [7:0]           dl_index,
    input  logic [15:0]          dl_ext,
    input  logic [BANK_W-1:0]    bank_sel,
    output logic                 wr_req,
    input  logic                 wr_ack,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [7:0]           wr_data,
    output logic [BANK_W-1:0]    wr_bank,
    input  logic [PAGE_BITS-1:0] map_page,
    output logic                 map_valid,
    output logic                 busy,
    output logic                 err_ext,
    output logic                 err_ovf
);

    typedef enum logic [2:0] {
        MODE_IDLE  = 3'd0,
        MODE_SYS   = 3'd1,
        MODE_EXP   = 3'd2,
        MODE_COMBO = 3'd3,
        MODE_BAD   = 3'd4
    } mode_t;

    // {valid, value} for one ASCII hex digit; only 0-9 and upper-case A-F are accepted
    function automatic logic [4:0] hex_nib(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) begin
            hex_nib = {1'b1, c[3:0]};
        end else if (c >= 8'h41 && c <= 8'h46) begin
            hex_nib = {1'b1, c[3:0] + 4'd9};
        end else begin
            hex_nib = 5'd0;
        end
    endfunction

    function automatic logic [PAGE_BITS-1:0] fit_page(input logic [31:0] v);
        fit_page = v[PAGE_BITS-1:0];
    endfunction

    function automatic logic [BANK_W-1:0] bank_of(input logic [31:0] chunk);
        logic [31:0] sh;
        sh      = chunk >> 2;
        bank_of = sh[BANK_W-1:0];
    endfunction

    logic                 dl_active_q, dl_active_d, dl_wr_q, dl_wr_d;
    logic                 act_rise_s, act_fall_s, wr_rise_s;
    logic [4:0]           hi_s, lo_s;
    mode_t                mode_q, mode_d;
    logic                 active_q, active_d, area_q, area_d;
    logic [PAGE_BITS-1:0] base_q, base_d;
    logic                 err_ext_q, err_ext_d, err_ovf_q, err_ovf_d;
    logic                 stg_vld_q, stg_vld_d;
    logic [24:0]          stg_addr_q, stg_addr_d;
    logic [7:0]           stg_data_q, stg_data_d;
    logic [BANK_W-1:0]    stg_bank_q, stg_bank_d;
    logic [31:0]          chunk_s;
    logic [PAGE_BITS-1:0] exp_page_s, res_page_s;
    logic                 res_keep_s, res_area_s, push_s, pop_s, full_s, do_push_s;
    logic [BANK_W-1:0]    res_bank_s;
    logic [ADDR_W-1:0]    fifo_addr_q [2], fifo_addr_d [2];
    logic [7:0]           fifo_data_q [2], fifo_data_d [2];
    logic [BANK_W-1:0]    fifo_bank_q [2], fifo_bank_d [2];
    logic                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]           count_q, count_d;
    logic                 map_valid_q, map_valid_d;

    assign act_rise_s = dl_active & ~dl_active_q;
    assign act_fall_s = ~dl_active & dl_active_q;
    assign wr_rise_s  = dl_wr & ~dl_wr_q;

    // Download mode: decoded once per download at the dl_active rising edge
    always_comb begin
        mode_d      = mode_q;
        active_d    = active_q;
        base_d      = base_q;
        area_d      = area_q;
        err_ext_d   = err_ext_q;
        dl_active_d = dl_active;
        dl_wr_d     = dl_wr;
        hi_s        = hex_nib(dl_ext[15:8]);
        lo_s        = hex_nib(dl_ext[7:0]);
        if (reset) begin
            mode_d    = MODE_IDLE;
            active_d  = 1'b0;
            base_d    = '0;
            area_d    = 1'b0;
            err_ext_d = 1'b0;
        end else if (act_rise_s) begin
            active_d  = 1'b1;
            err_ext_d = 1'b0;
            base_d    = '0;
            area_d    = 1'b0;
            if (dl_index == 8'd0) begin
                mode_d = MODE_SYS;
            end else if (dl_ext == 16'h5A5A) begin
                mode_d = MODE_EXP;
            end else if (dl_ext == 16'h5A30) begin
                mode_d = MODE_COMBO;
            end else if (hi_s[4] && lo_s[4]) begin
                mode_d = MODE_EXP;
                base_d = fit_page({24'd0, hi_s[3:0], lo_s[3:0]});
                area_d = 1'b1;
            end else begin
                mode_d    = MODE_BAD;
                err_ext_d = 1'b1;
            end
        end else if (act_fall_s) begin
            active_d = 1'b0;
        end else begin
            active_d = active_q;
        end
    end

    // Strobe capture: one raw entry per dl_wr rising edge; resolved against the mode on the next cycle
    always_comb begin
        stg_vld_d  = 1'b0;
        stg_addr_d = stg_addr_q;
        stg_data_d = stg_data_q;
        stg_bank_d = stg_bank_q;
        if (reset) begin
            stg_vld_d = 1'b0;
        end else if (wr_rise_s && dl_active) begin
            stg_vld_d  = 1'b1;
            stg_addr_d = dl_addr;
            stg_data_d = dl_data;
            stg_bank_d = bank_sel;
        end else begin
            stg_vld_d = 1'b0;
        end
    end

    assign chunk_s    = 32'(stg_addr_q[24:PAGE_SIZE_BITS]);
    assign exp_page_s = base_q + stg_addr_q[PAGE_BITS+PAGE_SIZE_BITS-1:PAGE_SIZE_BITS];

    // Target resolution: {area, page, bank} for the staged byte, or discard
    always_comb begin
        res_keep_s = 1'b0;
        res_area_s = 1'b0;
        res_page_s = '0;
        res_bank_s = stg_bank_q;
        case (mode_q)
            MODE_EXP: begin
                res_keep_s = 1'b1;
                res_area_s = area_q;
                res_page_s = exp_page_s;
            end
            MODE_COMBO: begin
                res_keep_s = 1'b1;
                if (chunk_s == 32'd0) begin
                    res_area_s = area_q;
                    res_page_s = exp_page_s;
                end else begin
                    res_area_s = 1'b1;
                    res_page_s = fit_page(32'(COMBO_PAGE) + chunk_s - 32'd1);
                end
            end
            MODE_SYS: begin
                if (chunk_s < 32'(4 * NUM_BANKS)) begin
                    res_keep_s = 1'b1;
                    res_bank_s = bank_of(chunk_s);
                    case (chunk_s[1:0])
                        2'd0:    begin res_area_s = 1'b0; res_page_s = '0;               end
                        2'd1:    begin res_area_s = 1'b1; res_page_s = '0;               end
                        2'd2:    begin res_area_s = 1'b1; res_page_s = fit_page(32'd7);  end
                        default: begin res_area_s = 1'b1; res_page_s = '1;               end
                    endcase
                end else begin
                    res_keep_s = 1'b0;
                end
            end
            default: res_keep_s = 1'b0;
        endcase
    end

    assign push_s    = stg_vld_q & res_keep_s;
    assign pop_s     = (count_q != 2'd0) & wr_ack;
    assign full_s    = (count_q == 2'd2);
    assign do_push_s = push_s & (~full_s | pop_s);

    // Write FIFO; a push into a full FIFO only succeeds when the head pops in the same cycle
    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        fifo_bank_d = fifo_bank_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        err_ovf_d   = err_ovf_q;
        if (reset) begin
            wr_ptr_d  = 1'b0;
            rd_ptr_d  = 1'b0;
            count_d   = 2'd0;
            err_ovf_d = 1'b0;
        end else begin
            if (do_push_s) begin
                fifo_addr_d[wr_ptr_q] = {res_area_s, res_page_s, stg_addr_q[PAGE_SIZE_BITS-1:0]};
                fifo_data_d[wr_ptr_q] = stg_data_q;
                fifo_bank_d[wr_ptr_q] = res_bank_s;
                wr_ptr_d              = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + {1'b0, do_push_s} - {1'b0, pop_s};
            if (push_s && !do_push_s) begin
                err_ovf_d = 1'b1;
            end else if (act_rise_s) begin
                err_ovf_d = 1'b0;
            end else begin
                err_ovf_d = err_ovf_q;
            end
        end
    end

`ifdef ROM_PAGE_LOADER_MAP_EN
    logic [(1 << PAGE_BITS)-1:0] map_q, map_d;

    // Loaded-page map: marks area-1 pages as their writes leave the FIFO
    always_comb begin
        map_d       = map_q;
        map_valid_d = 1'b0;
        if (reset) begin
            map_d       = '0;
            map_valid_d = 1'b0;
        end else begin
            map_valid_d = map_q[map_page];
            if (pop_s && wr_addr[ADDR_W-1]) begin
                map_d[wr_addr[ADDR_W-2:PAGE_SIZE_BITS]] = 1'b1;
            end else begin
                map_d = map_q;
            end
        end
    end

    // Map storage
    always_ff @(posedge clk_sys) begin
        map_q <= map_d;
    end
`else
    logic map_page_unused_s;
    assign map_page_unused_s = ^map_page;

    // Without a map every page reports loaded once out of reset
    always_comb begin
        map_valid_d = 1'b0;
        if (reset) begin
            map_valid_d = 1'b0;
        end else begin
            map_valid_d = 1'b1;
        end
    end
`endif

    // State registers; reset is folded into the _d logic above
    always_ff @(posedge clk_sys) begin
        dl_active_q <= dl_active_d;
        dl_wr_q     <= dl_wr_d;
        mode_q      <= mode_d;
        active_q    <= active_d;
        base_q      <= base_d;
        area_q      <= area_d;
        err_ext_q   <= err_ext_d;
        err_ovf_q   <= err_ovf_d;
        stg_vld_q   <= stg_vld_d;
        stg_addr_q  <= stg_addr_d;
        stg_data_q  <= stg_data_d;
        stg_bank_q  <= stg_bank_d;
        fifo_addr_q <= fifo_addr_d;
        fifo_data_q <= fifo_data_d;
        fifo_bank_q <= fifo_bank_d;
        wr_ptr_q    <= wr_ptr_d;
        rd_ptr_q    <= rd_ptr_d;
        count_q     <= count_d;
        map_valid_q <= map_valid_d;
    end

    assign wr_req    = (count_q != 2'd0);
    assign wr_addr   = fifo_addr_q[rd_ptr_q];
    assign wr_data   = fifo_data_q[rd_ptr_q];
    assign wr_bank   = fifo_bank_q[rd_ptr_q];
    assign busy      = active_q | stg_vld_q | (count_q != 2'd0);
    assign err_ext   = err_ext_q;
    assign err_ovf   = err_ovf_q;
    assign map_valid = map_valid_q;

endmodule

// File: tb/tb_rom_page_loader.sv
// Self-checking bench for rom_page_loader: random bytes per download mode, compared with an address-rule model.
module tb_rom_page_loader;
    localparam int PB = 8;
    localparam int NB = 2;
    localparam int CP = 255;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        dl_active = 1'b0, dl_wr = 1'b0, wr_ack = 1'b1;
    logic [24:0] dl_addr = '0;
    logic [7:0]  dl_data = '0, dl_index = '0;
    logic [15:0] dl_ext = '0;
    logic        bank_sel = 1'b0, wr_bank;
    logic        wr_req, map_valid, busy, err_ext, err_ovf;
    logic [22:0] wr_addr;
    logic [7:0]  wr_data, map_page = '0;

    int errors = 0, checks = 0, req_seen = 0;
    logic [31:0] rec_q[$], exp_q[$];
    logic [15:0] cur_ext;
    logic [7:0]  cur_idx;
    bit          model_map [256];

    rom_page_loader dut (
        .clk_sys(clk_sys), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .dl_index(dl_index), .dl_ext(dl_ext),
        .bank_sel(bank_sel), .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_bank(wr_bank), .map_page(map_page), .map_valid(map_valid),
        .busy(busy), .err_ext(err_ext), .err_ovf(err_ovf)
    );

    always #5 clk_sys = ~clk_sys;

    // Write monitor: accepted writes are those with req and ack both high before the edge
    always @(negedge clk_sys) begin
        if (!reset && wr_req && wr_ack) rec_q.push_back({wr_bank, wr_addr, wr_data});
        if (wr_req) req_seen++;
    end

    function automatic int hexval(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        return -1;
    endfunction

    // Returns {keep, bank, area, page[7:0], offset[13:0], data}
    function automatic logic [32:0] model(input logic [15:0] ext, input logic [7:0] idx,
                                          input logic [24:0] a, input logic bsel, input logic [7:0] d);
        int c, hi, lo, area, page, bank;
        bit keep;
        c = int'(a) / 16384; keep = 1'b1; bank = int'(bsel); area = 0; page = 0;
        hi = hexval(ext[15:8]); lo = hexval(ext[7:0]);
        if (idx == 8'd0) begin
            bank = c / 4;
            area = (c % 4 == 0) ? 0 : 1;
            page = (c % 4 == 2) ? 7 : (c % 4 == 3) ? 255 : 0;
            if (c >= 4 * NB) keep = 1'b0;
        end else if (ext == "Z0" && c >= 1) begin
            area = 1; page = (CP + c - 1) % 256;
        end else if (ext == "ZZ" || ext == "Z0") begin
            page = c % 256;
        end else if (hi >= 0 && lo >= 0) begin
            area = 1; page = (hi * 16 + lo + c) % 256;
        end else begin
            keep = 1'b0;
        end
        return {keep, bank[0], area[0], page[7:0], a[13:0], d};
    endfunction

    function automatic bit exp_map(input int p);
`ifdef ROM_PAGE_LOADER_MAP_EN
        return model_map[p];
`else
        return (p >= 0);
`endif
    endfunction

    task automatic start_dl(input logic [15:0] ext, input logic [7:0] idx, input logic bsel);
        cur_ext = ext; cur_idx = idx;
        dl_ext = ext; dl_index = idx; bank_sel = bsel; dl_active = 1'b1;
        @(posedge clk_sys); #1;
    endtask

    task automatic end_dl();
        dl_active = 1'b0;
        @(posedge clk_sys); #1;
    endtask

    // One strobe of random width; the model decides whether a write is expected
    task automatic send(input logic [24:0] a, input logic [7:0] d);
        logic [32:0] m;
        m = model(cur_ext, cur_idx, a, bank_sel, d);
        if (m[32]) exp_q.push_back(m[31:0]);
        dl_addr = a; dl_data = d; dl_wr = 1'b1;
        repeat ($urandom_range(1, 3)) begin @(posedge clk_sys); #1; end
        dl_wr = 1'b0;
        @(posedge clk_sys); #1;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) begin ok = 1'b1; break; end
            @(posedge clk_sys); #1;
        end
        @(posedge clk_sys); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_sys); #1;
        checks++; if (wr_req !== 1'b0)    begin errors++; $display("FAIL rst_wr_req: got %b want 0", wr_req); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if ({err_ext, err_ovf} !== 2'b00) begin errors++; $display("FAIL rst_err: got %b want 00", {err_ext, err_ovf}); end
        checks++; if (map_valid !== 1'b0) begin errors++; $display("FAIL rst_map_valid: got %b want 0", map_valid); end
        reset = 1'b0;
        repeat (2) @(posedge clk_sys); #1;
        checks++; if (map_valid !== exp_map(0)) begin errors++; $display("FAIL rel_map_valid: got %b want %b", map_valid, exp_map(0)); end
    endtask

    task automatic test_expansion();
        logic [32:0] m;
        bit ok;
        wr_ack = 1'b0;
        start_dl("3A", 8'd1, 1'b1);
        m = model(cur_ext, cur_idx, 25'h0, 1'b1, 8'hC5);
        exp_q.push_back(m[31:0]);
        dl_addr = 25'h0; dl_data = 8'hC5; dl_wr = 1'b1;
        @(negedge clk_sys); @(negedge clk_sys);
        checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL lat_early: wr_req %b want 0", wr_req); end
        @(negedge clk_sys);
        checks++; if (wr_req !== 1'b1) begin errors++; $display("FAIL lat_2cyc: wr_req %b want 1", wr_req); end
        checks++; if ({wr_bank, wr_addr, wr_data} !== m[31:0]) begin errors++; $display("FAIL lat_head: got %h want %h", {wr_bank, wr_addr, wr_data}, m[31:0]); end
        @(posedge clk_sys); #1;
        dl_wr = 1'b0; wr_ack = 1'b1;
        @(posedge clk_sys); #1;
        send(25'h4000, 8'($urandom));
        end_dl();
        for (int k = 0; k < 3; k++) begin
            int v;
            logic [7:0] h, l;
            v = $urandom_range(0, 255);
            h = (v / 16 < 10) ? 8'(48 + v / 16) : 8'(55 + v / 16);
            l = (v % 16 < 10) ? 8'(48 + v % 16) : 8'(55 + v % 16);
            start_dl({h, l}, 8'($urandom_range(1, 255)), 1'($urandom));
            repeat (4) send(25'($urandom), 8'($urandom));
            end_dl();
        end
        start_dl("ZZ", 8'd3, 1'b0);
        send(25'h0123, 8'h5A);
        send(25'h8001, 8'hA5);
        end_dl();
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL exp_drain: busy still %b", busy); end
        checks++; if (rec_q.size() !== exp_q.size()) begin errors++; $display("FAIL exp_count: got %0d want %0d", rec_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rec_q.size(); i++) begin
            checks++; if (rec_q[i] !== exp_q[i]) begin errors++; $display("FAIL exp_write[%0d]: got %h want %h", i, rec_q[i], exp_q[i]); end
        end
        foreach (exp_q[i]) if (exp_q[i][30]) model_map[exp_q[i][29:22]] = 1'b1;
        rec_q.delete(); exp_q.delete();
        for (int p = 8'h3A; p <= 8'h3B; p++) begin
            map_page = 8'(p);
            @(posedge clk_sys); #1;
            checks++; if (map_valid !== exp_map(p)) begin errors++; $display("FAIL exp_map[%h]: got %b want %b", p, map_valid, exp_map(p)); end
        end
    endtask

    task automatic test_bad_ext();
        bit ok;
        req_seen = 0;
        start_dl("Q7", 8'd1, 1'b0);
        repeat (10) send(25'($urandom), 8'($urandom));
        checks++; if (err_ext !== 1'b1) begin errors++; $display("FAIL bad_err_ext: got %b want 1", err_ext); end
        end_dl();
        wait_idle(ok);
        checks++; if (req_seen !== 0) begin errors++; $display("FAIL bad_no_req: wr_req seen %0d cycles want 0", req_seen); end
        checks++; if (rec_q.size() !== 0) begin errors++; $display("FAIL bad_writes: got %0d want 0", rec_q.size()); end
        map_page = 8'h3A;
        @(posedge clk_sys); #1;
        checks++; if (map_valid !== exp_map(8'h3A)) begin errors++; $display("FAIL bad_map: got %b want %b", map_valid, exp_map(8'h3A)); end
        rec_q.delete(); exp_q.delete();
    endtask

    task automatic test_combo();
        bit ok;
        logic [24:0] addrs [7];
        addrs = '{25'h0, 25'h3FFF, 25'($urandom_range(0, 16383)), 25'h4000, 25'h7FFF,
                  25'($urandom_range(16384, 32767)), 25'h8000};
        start_dl("Z0", 8'd2, 1'($urandom));
        checks++; if (err_ext !== 1'b0) begin errors++; $display("FAIL combo_err_ext: got %b want 0", err_ext); end
        foreach (addrs[i]) send(addrs[i], 8'($urandom));
        end_dl();
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL combo_drain: busy still %b", busy); end
        checks++; if (rec_q.size() !== exp_q.size()) begin errors++; $display("FAIL combo_count: got %0d want %0d", rec_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rec_q.size(); i++) begin
            checks++; if (rec_q[i] !== exp_q[i]) begin errors++; $display("FAIL combo_write[%0d]: got %h want %h", i, rec_q[i], exp_q[i]); end
        end
        foreach (exp_q[i]) if (exp_q[i][30]) model_map[exp_q[i][29:22]] = 1'b1;
        rec_q.delete(); exp_q.delete();
    endtask

    task automatic test_system();
        bit ok;
        start_dl("XX", 8'd0, 1'($urandom));
        for (int c = 0; c < 9; c++) send(25'(c * 16384 + $urandom_range(0, 16383)), 8'($urandom));
        end_dl();
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL sys_drain: busy still %b", busy); end
        checks++; if (rec_q.size() !== exp_q.size()) begin errors++; $display("FAIL sys_count: got %0d want %0d", rec_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rec_q.size(); i++) begin
            checks++; if (rec_q[i] !== exp_q[i]) begin errors++; $display("FAIL sys_write[%0d]: got %h want %h", i, rec_q[i], exp_q[i]); end
        end
        foreach (exp_q[i]) if (exp_q[i][30]) model_map[exp_q[i][29:22]] = 1'b1;
        rec_q.delete(); exp_q.delete();
    endtask

    task automatic test_overflow();
        bit ok;
        wr_ack = 1'b0;
        start_dl("10", 8'd1, 1'($urandom));
        repeat (3) send(25'($urandom), 8'($urandom));
        void'(exp_q.pop_back());
        checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", err_ovf); end
        checks++; if (wr_req !== 1'b1) begin errors++; $display("FAIL ovf_req: got %b want 1", wr_req); end
        checks++; if ({wr_bank, wr_addr, wr_data} !== exp_q[0]) begin errors++; $display("FAIL ovf_head: got %h want %h", {wr_bank, wr_addr, wr_data}, exp_q[0]); end
        wr_ack = 1'b1;
        end_dl();
        wait_idle(ok);
        checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", err_ovf); end
        checks++; if (rec_q.size() !== exp_q.size()) begin errors++; $display("FAIL ovf_count: got %0d want %0d", rec_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rec_q.size(); i++) begin
            checks++; if (rec_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_write[%0d]: got %h want %h", i, rec_q[i], exp_q[i]); end
        end
        foreach (exp_q[i]) if (exp_q[i][30]) model_map[exp_q[i][29:22]] = 1'b1;
        rec_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        bit ok;
        start_dl("40", 8'd1, 1'($urandom));
        checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL mid_ovf_clear: got %b want 0", err_ovf); end
        for (int i = 0; i < 5; i++) send(25'(i * 7), 8'($urandom));
        repeat (3) @(posedge clk_sys); #1;
        checks++; if (rec_q.size() !== exp_q.size()) begin errors++; $display("FAIL mid_count: got %0d want %0d", rec_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rec_q.size(); i++) begin
            checks++; if (rec_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_write[%0d]: got %h want %h", i, rec_q[i], exp_q[i]); end
        end
        foreach (exp_q[i]) if (exp_q[i][30]) model_map[exp_q[i][29:22]] = 1'b1;
        rec_q.delete(); exp_q.delete();
        map_page = 8'h40;
        @(posedge clk_sys); #1;
        checks++; if (map_valid !== exp_map(8'h40)) begin errors++; $display("FAIL mid_map_pre: got %b want %b", map_valid, exp_map(8'h40)); end
        wr_ack = 1'b0;
        send(25'h5, 8'h99);
        void'(exp_q.pop_back());
        reset = 1'b1;
        @(posedge clk_sys); #1;
        foreach (model_map[p]) model_map[p] = 1'b0;
        checks++; if ({wr_req, busy, err_ext, err_ovf, map_valid} !== 5'b0) begin errors++; $display("FAIL mid_reset: req/busy/ext/ovf/mv got %b want 00000", {wr_req, busy, err_ext, err_ovf, map_valid}); end
        reset = 1'b0; wr_ack = 1'b1; req_seen = 0;
        for (int i = 5; i < 9; i++) send(25'(i * 7), 8'($urandom));
        end_dl();
        wait_idle(ok);
        checks++; if (req_seen !== 0 || rec_q.size() !== 0) begin errors++; $display("FAIL mid_no_writes: got %0d req cycles, %0d writes want 0", req_seen, rec_q.size()); end
        checks++; if (map_valid !== exp_map(8'h40)) begin errors++; $display("FAIL mid_map_post: got %b want %b", map_valid, exp_map(8'h40)); end
        rec_q.delete(); exp_q.delete();
    endtask

    initial begin
        foreach (model_map[p]) model_map[p] = 1'b0;
        test_reset();
        test_expansion();
        test_bad_ext();
        test_combo();
        test_system();
        test_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
